imem_port_arbiter: RTL

- Shares the single combinational, byte-addressed, little-endian 32-bit memory read port between two requesters: instruction fetch (IF) and data load (LD).
- Grants at most one request per cycle and registers the returned word into a per-requester response buffer with valid/ready backpressure.
- Flags out-of-range and misaligned accesses.
- Sits between the fetch/MEM stages and the memory read block.

---
 rtl/imem_port_arbiter_pkg.sv | 18 +
 rtl/imem_port_arbiter_if.sv | 17 +
 rtl/imem_port_arbiter_rsp_buffer.sv | 28 ++
 rtl/imem_port_arbiter.sv | 76 +++++++
 4 files changed

// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory read-port arbiter.
package imem_port_arbiter_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REQ    = 2;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LD = 1'b1
  } req_idx_e;

  // Misaligned word, or a word that would run past the last byte of memory.
  function automatic logic addr_err(input logic [DATA_WIDTH-1:0] addr,
                                    input int unsigned depth);
    logic [DATA_WIDTH-1:0] lim;
    lim = DATA_WIDTH'(depth - 32'd4);
    return (addr[1:0] != 2'b00) || (addr > lim);
  endfunction
endpackage

// File: rtl/imem_port_arbiter_if.sv
// One requester's request/response channel into the memory read-port arbiter.
interface imem_port_arbiter_if
  import imem_port_arbiter_pkg::*;
;
  logic                  req_valid;
  logic [DATA_WIDTH-1:0] req_addr;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_error;
  logic                  rsp_ready;

  modport master (output req_valid, req_addr, rsp_ready,
                  input  req_ready, rsp_valid, rsp_data, rsp_error);
  modport slave  (input  req_valid, req_addr, rsp_ready,
                  output req_ready, rsp_valid, rsp_data, rsp_error);
endinterface

// File: rtl/imem_port_arbiter_rsp_buffer.sv
// One-entry response register; a new load wins over a drain in the same cycle.
module rsp_buffer
  import imem_port_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  load_err,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  rsp_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= load_data;
      rsp_error <= load_err;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one combinational memory read port between fetch (IF) and load (LD),
// LD-priority with a starvation override for IF.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_DEPTH = 100,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_port_arbiter_if.slave    if_port,
  imem_port_arbiter_if.slave    ld_port,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_code,
  input  logic                  mem_error
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [NUM_REQ-1:0]                 req_valid, rsp_ready, rsp_valid, rsp_error;
  logic [NUM_REQ-1:0]                 elig, gnt;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_addr, rsp_data;
  logic [CW-1:0]                      starve_cnt;
  logic                               force_if, err;
  logic [DATA_WIDTH-1:0]              load_data;

  assign req_valid[REQ_IF] = if_port.req_valid;
  assign req_valid[REQ_LD] = ld_port.req_valid;
  assign req_addr[REQ_IF]  = if_port.req_addr;
  assign req_addr[REQ_LD]  = ld_port.req_addr;
  assign rsp_ready[REQ_IF] = if_port.rsp_ready;
  assign rsp_ready[REQ_LD] = ld_port.rsp_ready;

  // A full buffer only accepts a new grant when it is draining this cycle.
  assign elig     = req_valid & (~rsp_valid | rsp_ready);
  assign force_if = (starve_cnt == CW'(MAX_WAIT));

  always_comb begin
    gnt         = '0;
    gnt[REQ_IF] = elig[REQ_IF] & (~elig[REQ_LD] | force_if);
    gnt[REQ_LD] = elig[REQ_LD] & ~gnt[REQ_IF];
  end

  assign mem_addr  = gnt[REQ_IF] ? req_addr[REQ_IF] :
                     gnt[REQ_LD] ? req_addr[REQ_LD] : '0;
  assign err       = mem_error | addr_err(mem_addr, DATA_DEPTH);
  assign load_data = err ? '0 : mem_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               starve_cnt <= '0;
    else if (elig[REQ_IF] && !gnt[REQ_IF]) starve_cnt <= force_if ? starve_cnt : starve_cnt + 1'b1;
    else                                   starve_cnt <= '0;
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_buf
    rsp_buffer u_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (gnt[g]),
      .load_err  (err),
      .load_data (load_data),
      .rsp_ready (rsp_ready[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_data  (rsp_data[g]),
      .rsp_error (rsp_error[g])
    );
  end

  assign if_port.req_ready = gnt[REQ_IF];
  assign ld_port.req_ready = gnt[REQ_LD];
  assign if_port.rsp_valid = rsp_valid[REQ_IF];
  assign ld_port.rsp_valid = rsp_valid[REQ_LD];
  assign if_port.rsp_data  = rsp_data[REQ_IF];
  assign ld_port.rsp_data  = rsp_data[REQ_LD];
  assign if_port.rsp_error = rsp_error[REQ_IF];
  assign ld_port.rsp_error = rsp_error[REQ_LD];
endmodule
